// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// two requesters (A, B). Each grant captures a one- or two-word payload and
// streams it into the FIFO one word per cycle, stalling while wfull is high.
module fifo_wr_arbiter #(
    parameter int data_width = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_a,
    input  logic [2*data_width-1:0] data_a,
    input  logic                    two_a,
    output logic                    ack_a,
    input  logic                    req_b,
    input  logic [2*data_width-1:0] data_b,
    input  logic                    two_b,
    output logic                    ack_b,
    input  logic                    wfull,
    output logic                    winc,
    output logic [data_width-1:0]   wdata,
    output logic                    busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_t;

    // One requester's payload: length flag plus both words.
    typedef struct packed {
        logic                    two;
        logic [2*data_width-1:0] data;
    } req_t;

    state_t                  state, state_nxt;
    logic                    prio, prio_nxt;    // 0 = A favoured, 1 = B favoured
    logic                    owner, owner_nxt;  // requester owning the current transfer
    logic                    two_r, two_nxt;
    logic [2*data_width-1:0] buf_r, buf_nxt;
    logic [1:0]              ack_r, ack_nxt;

    logic [1:0]              req;
    logic [1:0]              gnt;
    req_t [1:0]              rq;

    assign req   = {req_b, req_a};
    assign rq[0] = {two_a, data_a};
    assign rq[1] = {two_b, data_b};

    // A lone requester always wins; on contention prio breaks the tie.
    assign gnt[0] = req[0] & (~req[1] | ~prio);
    assign gnt[1] = req[1] & (~req[0] |  prio);

    // Next-state, capture and fairness update; prio only moves on completion.
    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        owner_nxt = owner;
        two_nxt   = two_r;
        buf_nxt   = buf_r;
        ack_nxt   = 2'b00;
        unique case (state)
            IDLE: begin
                if (|gnt) begin
                    owner_nxt = gnt[1];
                    two_nxt   = rq[gnt[1]].two;
                    buf_nxt   = rq[gnt[1]].data;
                    ack_nxt   = gnt;
                    state_nxt = BEAT0;
                end
            end
            BEAT0: begin
                if (!wfull) begin
                    if (two_r) begin
                        state_nxt = BEAT1;
                    end else begin
                        state_nxt = IDLE;
                        prio_nxt  = ~owner;
                    end
                end
            end
            BEAT1: begin
                if (!wfull) begin
                    state_nxt = IDLE;
                    prio_nxt  = ~owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and payload registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            owner <= 1'b0;
            two_r <= 1'b0;
            buf_r <= '0;
            ack_r <= 2'b00;
        end else begin
            state <= state_nxt;
            prio  <= prio_nxt;
            owner <= owner_nxt;
            two_r <= two_nxt;
            buf_r <= buf_nxt;
            ack_r <= ack_nxt;
        end
    end

    // Write strobe never fires while full; data is a pure register mux.
    assign winc  = (state != IDLE) & ~wfull;
    assign wdata = (state == BEAT1) ? buf_r[2*data_width-1:data_width]
                                    : buf_r[data_width-1:0];
    assign busy  = (state != IDLE);
    assign ack_a = ack_r[0];
    assign ack_b = ack_r[1];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed latency/stall/reset scenarios plus a randomized
// two-requester run scored against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_a = 1'b0, two_a = 1'b0, req_b = 1'b0, two_b = 1'b0;
    logic          wfull = 1'b0;
    logic [2*DW-1:0] data_a = '0, data_b = '0;
    logic          ack_a, ack_b, winc, busy;
    logic [DW-1:0] wdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] wr_log[$];
    logic          full_log[$];

    fifo_wr_arbiter #(.data_width(DW)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .two_a(two_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .two_b(two_b), .ack_b(ack_b),
        .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Record every write strobe mid-cycle, with the full flag seen alongside it.
    always @(negedge clk) begin
        if (winc === 1'b1) begin
            wr_log.push_back(wdata);
            full_log.push_back(wfull);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ack_a, ack_b, winc, busy, wdata} !== '0)
            $display("FAIL reset_outputs: got ack_a=%b ack_b=%b winc=%b busy=%b wdata=%h, expected all 0",
                     ack_a, ack_b, winc, busy, wdata);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int base;
        base = wr_log.size();
        req_a = 1'b1; data_a = 16'h00A5; two_a = 1'b0;
        tick();
        checks++;
        if ({ack_a, ack_b, winc, busy} !== 4'b1011 || wdata !== 8'hA5) begin
            errors++;
            $display("FAIL single_grant: got ack_a=%b ack_b=%b winc=%b busy=%b wdata=%h, expected 1 0 1 1 a5",
                     ack_a, ack_b, winc, busy, wdata);
        end
        req_a = 1'b0;
        tick();
        checks++;
        if ({ack_a, ack_b, winc, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL single_done: got ack_a=%b ack_b=%b winc=%b busy=%b, expected all 0",
                     ack_a, ack_b, winc, busy);
        end
        checks++;
        if (wr_log.size() - base != 1 || wr_log[base] !== 8'hA5) begin
            errors++;
            $display("FAIL single_log: got %0d writes (first %h), expected 1 write of a5",
                     wr_log.size() - base, (wr_log.size() > base) ? wr_log[base] : 8'hxx);
        end
    endtask

    task automatic test_two_word();
        req_b = 1'b1; data_b = 16'h3C5A; two_b = 1'b1;
        tick();
        checks++;
        if ({ack_a, ack_b, winc, busy} !== 4'b0111 || wdata !== 8'h5A) begin
            errors++;
            $display("FAIL two_beat0: got ack_a=%b ack_b=%b winc=%b busy=%b wdata=%h, expected 0 1 1 1 5a",
                     ack_a, ack_b, winc, busy, wdata);
        end
        req_b = 1'b0; data_b = 16'hFFFF;  // payload is already captured
        tick();
        checks++;
        if ({ack_a, ack_b, winc, busy} !== 4'b0011 || wdata !== 8'h3C) begin
            errors++;
            $display("FAIL two_beat1: got ack_a=%b ack_b=%b winc=%b busy=%b wdata=%h, expected 0 0 1 1 3c",
                     ack_a, ack_b, winc, busy, wdata);
        end
        tick();
        checks++;
        if ({winc, busy} !== 2'b00) begin
            errors++;
            $display("FAIL two_done: got winc=%b busy=%b, expected 0 0", winc, busy);
        end
        // B just completed, so A must win a tie now.
        req_a = 1'b1; data_a = 16'h0011; two_a = 1'b0;
        req_b = 1'b1; data_b = 16'h0022; two_b = 1'b0;
        tick();
        checks++;
        if ({ack_a, ack_b} !== 2'b10) begin
            errors++;
            $display("FAIL two_prio_a: got ack_a=%b ack_b=%b, expected 1 0", ack_a, ack_b);
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_contention();
        int base;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        base = wr_log.size();
        req_a = 1'b1; data_a = 16'h0011; two_a = 1'b0;
        req_b = 1'b1; data_b = 16'h0022; two_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic ea, eb, ew;
            logic [DW-1:0] ed;
            tick();
            ea = (i % 4 == 0);
            eb = (i % 4 == 2);
            ew = (i % 2 == 0);
            ed = (i % 4 == 0) ? 8'h11 : 8'h22;
            checks++;
            if (ack_a !== ea || ack_b !== eb || winc !== ew || (ew && wdata !== ed)) begin
                errors++;
                $display("FAIL contention_cycle%0d: got ack_a=%b ack_b=%b winc=%b wdata=%h, expected %b %b %b %h",
                         i, ack_a, ack_b, winc, wdata, ea, eb, ew, ed);
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        checks++;
        if (wr_log.size() - base != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d writes, expected 4", wr_log.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic [DW-1:0] ed;
                ed = (i % 2 == 0) ? 8'h11 : 8'h22;
                checks++;
                if (wr_log[base+i] !== ed) begin
                    errors++;
                    $display("FAIL contention_word%0d: got %h, expected %h", i, wr_log[base+i], ed);
                end
            end
        end
    endtask

    task automatic test_stall();
        int base;
        base = wr_log.size();
        req_a = 1'b1; data_a = 16'hBEEF; two_a = 1'b1;
        tick();
        checks++;
        if (winc !== 1'b1 || wdata !== 8'hEF) begin
            errors++;
            $display("FAIL stall_beat0: got winc=%b wdata=%h, expected 1 ef", winc, wdata);
        end
        req_a = 1'b0;
        tick();
        wfull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (winc !== 1'b0 || busy !== 1'b1 || wdata !== 8'hBE) begin
                errors++;
                $display("FAIL stall_hold%0d: got winc=%b busy=%b wdata=%h, expected 0 1 be",
                         i, winc, busy, wdata);
            end
            tick();
        end
        wfull = 1'b0;
        #1;
        checks++;
        if (winc !== 1'b1 || wdata !== 8'hBE) begin
            errors++;
            $display("FAIL stall_release: got winc=%b wdata=%h, expected 1 be", winc, wdata);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || wr_log.size() - base != 2 || wr_log[base] !== 8'hEF ||
            wr_log[base+1] !== 8'hBE || full_log[base] !== 1'b0 || full_log[base+1] !== 1'b0) begin
            errors++;
            $display("FAIL stall_log: got busy=%b writes=%0d, expected busy=0 and writes ef,be with wfull low",
                     busy, wr_log.size() - base);
        end
    endtask

    task automatic test_reset_midop();
        int base;
        // A completed last, so B is favoured going in; reset must restore A.
        req_a = 1'b1; data_a = 16'h7788; two_a = 1'b1;
        tick();
        req_a = 1'b0;
        tick();
        checks++;
        if (winc !== 1'b1 || busy !== 1'b1 || wdata !== 8'h77) begin
            errors++;
            $display("FAIL midop_beat1: got winc=%b busy=%b wdata=%h, expected 1 1 77", winc, busy, wdata);
        end
        base = wr_log.size();
        rst = 1'b1;
        #1;
        checks++;
        if ({winc, busy, ack_a, ack_b} !== 4'b0000) begin
            errors++;
            $display("FAIL midop_async: got winc=%b busy=%b ack_a=%b ack_b=%b, expected all 0",
                     winc, busy, ack_a, ack_b);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (wr_log.size() != base) begin
            errors++;
            $display("FAIL midop_discard: got %0d extra writes, expected 0", wr_log.size() - base);
        end
        req_a = 1'b1; data_a = 16'h0011; two_a = 1'b0;
        req_b = 1'b1; data_b = 16'h0022; two_b = 1'b0;
        tick();
        checks++;
        if ({ack_a, ack_b} !== 2'b10) begin
            errors++;
            $display("FAIL midop_prio: got ack_a=%b ack_b=%b, expected 1 0", ack_a, ack_b);
        end
        req_a = 1'b0; req_b = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_random();
        localparam int NA = 6;
        localparam int NB = 4;
        logic [2*DW:0] qa[NA];
        logic [2*DW:0] qb[NB];
        logic [DW-1:0] exp_q[$];
        int ia, ib, sa, sb, base, reads, occ, cyc;
        logic pr, pick_b;
        logic [2*DW:0] r;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NA; i++) qa[i] = {1'($urandom_range(0, 1)), 16'($urandom)};
        for (int i = 0; i < NB; i++) qb[i] = {1'($urandom_range(0, 1)), 16'($urandom)};

        // Both sides always have work pending, so grants alternate from A
        // until one side runs dry.
        ia = 0; ib = 0; pr = 1'b0;
        while (ia < NA || ib < NB) begin
            pick_b = (ib < NB) && (ia >= NA || pr);
            r = pick_b ? qb[ib] : qa[ia];
            if (pick_b) ib++; else ia++;
            exp_q.push_back(r[DW-1:0]);
            if (r[2*DW]) exp_q.push_back(r[2*DW-1:DW]);
            pr = !pick_b;
        end

        base = wr_log.size();
        reads = 0; sa = 0; sb = 0;
        req_a = 1'b1; two_a = qa[0][2*DW]; data_a = qa[0][2*DW-1:0];
        req_b = 1'b1; two_b = qb[0][2*DW]; data_b = qb[0][2*DW-1:0];
        for (cyc = 0; cyc < 2000; cyc++) begin
            tick();
            if (ack_a) begin
                sa++;
                if (sa < NA) begin
                    two_a = qa[sa][2*DW]; data_a = qa[sa][2*DW-1:0];
                end else begin
                    req_a = 1'b0; data_a = 16'($urandom);
                end
            end
            if (ack_b) begin
                sb++;
                if (sb < NB) begin
                    two_b = qb[sb][2*DW]; data_b = qb[sb][2*DW-1:0];
                end else begin
                    req_b = 1'b0; data_b = 16'($urandom);
                end
            end
            // Depth-3 FIFO drained at a random, slower-than-write rate.
            occ = wr_log.size() - base - reads;
            if (occ > 0 && $urandom_range(0, 2) == 0) reads++;
            occ = wr_log.size() - base - reads;
            wfull = (occ >= 3);
            if (sa == NA && sb == NB && !busy) break;
        end
        wfull = 1'b0;
        checks++;
        if (cyc >= 2000) begin
            errors++;
            $display("FAIL random_timeout: acks a=%0d b=%0d after %0d cycles, expected %0d %0d",
                     sa, sb, cyc, NA, NB);
        end
        checks++;
        if (wr_log.size() - base != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d words, expected %0d", wr_log.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (wr_log[base+i] !== exp_q[i] || full_log[base+i] !== 1'b0) begin
                    errors++;
                    $display("FAIL random_word%0d: got %h (wfull=%b), expected %h with wfull=0",
                             i, wr_log[base+i], full_log[base+i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_word();
        test_contention();
        test_stall();
        test_reset_midop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
